// File: rtl/axis_fifo_pkt.sv
// AXI-Stream synchronous FIFO, first-word fall-through, with tlast transport,
// optional store-and-forward packet mode, occupancy and almost-full/empty flags.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 16,
    parameter int PACKET_MODE        = 0,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    localparam int AW                = $clog2(FIFO_DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [AW:0]           level,
    output logic [AW:0]           pkt_count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_L    = (AW+1)'(ALMOST_FULL_LEVEL);
    localparam logic [AW:0] AE_L    = (AW+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [DATA_WIDTH:0] head;
    logic                full;
    logic                empty;
    logic                wr;
    logic                rd;
    logic                pkt_inc;
    logic                pkt_dec;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign s_ready = !full && !areset;
    assign wr      = s_valid && s_ready;
    assign rd      = m_valid && m_ready;

    // Full with no complete packet releases an oversize packet cut-through.
    assign m_valid = (PACKET_MODE != 0)
                   ? (!empty && ((pkt_count != '0) || full))
                   : !empty;

    assign head             = mem[rd_ptr];
    assign {m_last, m_data} = empty ? '0 : head;

    assign pkt_inc = wr && s_last;
    assign pkt_dec = rd && m_last;

    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    always_ff @(posedge aclk) begin
        if (wr)
            mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr && !rd)
                level <= level + ONE;
            else if (rd && !wr)
                level <= level - ONE;
            if (pkt_inc && !pkt_dec)
                pkt_count <= pkt_count + ONE;
            else if (pkt_dec && !pkt_inc)
                pkt_count <= pkt_count - ONE;
        end
    end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed bench for axis_fifo_pkt: one cut-through and one packet-mode
// instance share the input stimulus; each scenario checks the relevant one.
module tb_axis_fifo_pkt;

    logic        aclk;
    logic        areset;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_valid;
    logic        m_ready;

    logic        c_s_ready, c_m_last, c_m_valid, c_af, c_ae;
    logic [31:0] c_m_data;
    logic [4:0]  c_level, c_pkt;
    logic        p_s_ready, p_m_last, p_m_valid, p_af, p_ae;
    logic [31:0] p_m_data;
    logic [4:0]  p_level, p_pkt;

    int n_cmp = 0;
    int n_mis = 0;

    axis_fifo_pkt #(.PACKET_MODE(0)) u_cut (
        .aclk(aclk), .areset(areset),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(c_s_ready),
        .m_data(c_m_data), .m_last(c_m_last), .m_valid(c_m_valid), .m_ready(m_ready),
        .level(c_level), .pkt_count(c_pkt),
        .almost_full(c_af), .almost_empty(c_ae)
    );

    axis_fifo_pkt #(.PACKET_MODE(1)) u_pkt (
        .aclk(aclk), .areset(areset),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(p_s_ready),
        .m_data(p_m_data), .m_last(p_m_last), .m_valid(p_m_valid), .m_ready(m_ready),
        .level(p_level), .pkt_count(p_pkt),
        .almost_full(p_af), .almost_empty(p_ae)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic [4:0]  lvl;
        logic [4:0]  pc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        int wi;
        int ri;
        int cyc;
        logic do_wr;
        logic do_rd;

        vecs[0] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 5'd1, 5'd0};
        vecs[1] = '{1'b1, 32'hB2, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 5'd2, 5'd1};
        vecs[2] = '{1'b1, 32'hC3, 1'b0, 1'b1, 1'b1, 32'hB2, 1'b1, 5'd2, 5'd1};
        vecs[3] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hC3, 1'b0, 5'd1, 5'd0};
        vecs[4] = '{1'b1, 32'hD4, 1'b1, 1'b1, 1'b1, 32'hD4, 1'b1, 5'd1, 5'd1};
        vecs[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd0, 5'd0};
        vecs[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd0, 5'd0};
        vecs[7] = '{1'b1, 32'hE5, 1'b1, 1'b1, 1'b1, 32'hE5, 1'b1, 5'd1, 5'd1};
        vecs[8] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hE5, 1'b1, 5'd1, 5'd1};

        // Reset state
        areset  = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 32'(c_s_ready), 32'd0);
        chk("rst_m_valid", 32'(c_m_valid), 32'd0);
        chk("rst_m_data", c_m_data, 32'd0);
        chk("rst_m_last", 32'(c_m_last), 32'd0);
        chk("rst_level", 32'(c_level), 32'd0);
        chk("rst_pkt", 32'(c_pkt), 32'd0);
        chk("rst_af", 32'(c_af), 32'd0);
        chk("rst_ae", 32'(c_ae), 32'd1);
        chk("rst_p_m_valid", 32'(p_m_valid), 32'd0);
        chk("rst_p_af", 32'(p_af), 32'd0);
        chk("rst_p_ae", 32'(p_ae), 32'd1);
        areset = 1'b0;
        tick();
        chk("rel_s_ready", 32'(c_s_ready), 32'd1);

        // Table-driven cut-through vectors
        for (int k = 0; k < 9; k++) begin
            s_valid = vecs[k].sv;
            s_data  = vecs[k].sd;
            s_last  = vecs[k].sl;
            m_ready = vecs[k].mr;
            tick();
            chk($sformatf("vec%0d_m_valid", k), 32'(c_m_valid), 32'(vecs[k].mv));
            chk($sformatf("vec%0d_m_data", k), c_m_data, vecs[k].md);
            chk($sformatf("vec%0d_m_last", k), 32'(c_m_last), 32'(vecs[k].ml));
            chk($sformatf("vec%0d_level", k), 32'(c_level), 32'(vecs[k].lvl));
            chk($sformatf("vec%0d_pkt", k), 32'(c_pkt), 32'(vecs[k].pc));
            chk($sformatf("vec%0d_ae", k), 32'(c_ae), 32'(vecs[k].lvl <= 5'd4));
        end

        // Fill to full, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            tick();
            chk($sformatf("fill%0d_level", i), 32'(c_level), 32'(i + 1));
            chk($sformatf("fill%0d_af", i), 32'(c_af), 32'((i + 1) >= 12));
            chk($sformatf("fill%0d_s_ready", i), 32'(c_s_ready), 32'((i + 1) < 16));
        end
        s_data  = 32'hEE;
        m_ready = 1'b1;
        chk("full_s_ready", 32'(c_s_ready), 32'd0);
        chk("full_head", c_m_data, 32'd0);
        tick();
        chk("full_rd_level", 32'(c_level), 32'd15);
        chk("full_reopen", 32'(c_s_ready), 32'd1);
        s_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(c_m_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), c_m_data, 32'(i));
            tick();
        end
        chk("drain_empty_valid", 32'(c_m_valid), 32'd0);
        chk("drain_empty_level", 32'(c_level), 32'd0);

        // Streaming with wrap-around
        do_reset();
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 32'(i + 32'h100);
            tick();
            chk($sformatf("strm%0d_valid", i), 32'(c_m_valid), 32'd1);
            chk($sformatf("strm%0d_data", i), c_m_data, 32'(i + 32'h100));
            chk($sformatf("strm%0d_level", i), 32'(c_level), 32'd1);
        end
        s_valid = 1'b0;
        tick();
        chk("strm_end_level", 32'(c_level), 32'd0);

        // Store-and-forward packet
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(32'h50 + i);
            s_last  = (i == 4);
            tick();
            chk($sformatf("pkt_wr%0d_valid", i), 32'(p_m_valid), 32'(i == 4));
        end
        chk("pkt_count_1", 32'(p_pkt), 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("pkt_rd%0d_data", j), p_m_data, 32'(32'h50 + j));
            chk($sformatf("pkt_rd%0d_last", j), 32'(p_m_last), 32'(j == 4));
            tick();
            chk($sformatf("pkt_rd%0d_count", j), 32'(p_pkt), 32'(j < 4));
        end
        chk("pkt_done_valid", 32'(p_m_valid), 32'd0);

        // Oversize packet release, then a closing last beat flushes the rest
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            tick();
        end
        chk("ovs_level", 32'(p_level), 32'd16);
        chk("ovs_pkt", 32'(p_pkt), 32'd0);
        chk("ovs_valid", 32'(p_m_valid), 32'd1);
        wi = 16;
        ri = 0;
        cyc = 0;
        m_ready = 1'b1;
        while (ri < 21 && cyc < 300) begin
            s_valid = (wi < 21);
            s_data  = 32'(wi);
            s_last  = (wi == 20);
            do_wr = p_s_ready && s_valid;
            do_rd = p_m_valid;
            if (do_rd) begin
                chk($sformatf("ovs_rd%0d_data", ri), p_m_data, 32'(ri));
                chk($sformatf("ovs_rd%0d_last", ri), 32'(p_m_last), 32'(ri == 20));
                ri++;
            end
            if (do_wr)
                wi++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("ovs_all_read", 32'(ri), 32'd21);
        chk("ovs_end_level", 32'(p_level), 32'd0);

        // Simultaneous read/write at level 8
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(32'h80 + i);
            s_last  = (i == 7);
            tick();
        end
        chk("sim_start_level", 32'(c_level), 32'd8);
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_data = 32'(32'h90 + k);
            s_last = (k == 7);
            tick();
            chk($sformatf("sim%0d_level", k), 32'(c_level), 32'd8);
            chk($sformatf("sim%0d_pkt", k), 32'(c_pkt), 32'd1);
            chk($sformatf("sim%0d_data", k), c_m_data,
                (k + 1 < 8) ? 32'(32'h80 + k + 1) : 32'(32'h90 + k - 7));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Mid-operation reset at level 7
        do_reset();
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(32'h60 + i);
            tick();
        end
        s_valid = 1'b0;
        chk("mid_pre_level", 32'(c_level), 32'd7);
        areset = 1'b1;
        #1;
        chk("mid_level", 32'(c_level), 32'd0);
        chk("mid_pkt", 32'(c_pkt), 32'd0);
        chk("mid_m_valid", 32'(c_m_valid), 32'd0);
        chk("mid_m_data", c_m_data, 32'd0);
        chk("mid_s_ready", 32'(c_s_ready), 32'd0);
        #3;
        areset  = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h77;
        tick();
        s_valid = 1'b0;
        chk("post_rst_data", c_m_data, 32'h77);
        chk("post_rst_level", 32'(c_level), 32'd1);
        chk("post_rst_valid", 32'(c_m_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
